// File: rtl/pwm_decoder_if.sv
// pwm_decoder_if: servo PWM input and the decoded measurement outputs.
interface pwm_decoder_if;
    logic        pwm_in;
    logic [16:0] width_o;
    logic [20:0] period_o;
    logic [3:0]  position_o;
    logic        valid_o;
    logic        signal_ok;
    logic        err_range;
    logic        timeout_o;
    modport master (
        output pwm_in,
        input  width_o, period_o, position_o, valid_o, signal_ok, err_range, timeout_o
    );
    modport slave (
        input  pwm_in,
        output width_o, period_o, position_o, valid_o, signal_ok, err_range, timeout_o
    );
endinterface

// File: rtl/pwm_decoder.sv
// pwm_decoder: measures servo PWM high time and period, quantizes the position 0..9
// and flags out-of-range pulses and loss of signal.
module pwm_decoder #(
    parameter int MIN_PULSE = 50000,
    parameter int MAX_PULSE = 100000,
    parameter int TIMEOUT   = 1250000,
    parameter int BIN       = 5555
) (
    input  logic         clk_50MHz,
    input  logic         rst,
    pwm_decoder_if.slave bus
);
    typedef enum logic [1:0] {SYNC, WAIT_RISE, HIGH, LOW} cap_e;
    typedef enum logic {IDLE, CALC} calc_e;

    localparam logic [16:0] W_SAT  = 17'h1ffff;
    localparam logic [16:0] W_MIN  = 17'(MIN_PULSE);
    localparam logic [16:0] W_MAX  = 17'(MAX_PULSE);
    localparam logic [16:0] W_BIN  = 17'(BIN);
    localparam logic [16:0] W_HALF = 17'(BIN / 2);
    localparam logic [20:0] P_SAT  = 21'(TIMEOUT);

    logic        s1_q, s2_q, s3_q;
    logic [1:0]  fill_q;
    cap_e        st_q, st_d;
    logic [16:0] wcnt_q, wcnt_d, wlat_q, wlat_d, w_inc;
    logic [20:0] pcnt_q, pcnt_d, p_inc;
    logic        rise, fall, hand, tmo;

    calc_e       cs_q, cs_d;
    logic [16:0] qw_q, qw_d, rem_q, rem_d;
    logic [20:0] qp_q, qp_d;
    logic [3:0]  qpos_q, qpos_d;
    logic        in_rng, done;

    logic [16:0] wo_q, wo_d;
    logic [20:0] po_q, po_d;
    logic [3:0]  pos_q, pos_d;
    logic        vld_q, vld_d, ok_q, ok_d, err_q, err_d, to_q, to_d;

    assign rise  = s2_q & ~s3_q;
    assign fall  = ~s2_q & s3_q;
    assign w_inc = (wcnt_q == W_SAT) ? W_SAT : wcnt_q + 17'd1;
    assign p_inc = (pcnt_q >= P_SAT) ? P_SAT : pcnt_q + 21'd1;

    // The period counter runs in every state so loss of signal is seen even before the first pulse.
    always_comb begin
        st_d   = st_q;
        wcnt_d = wcnt_q;
        wlat_d = wlat_q;
        pcnt_d = p_inc;
        hand   = 1'b0;
        tmo    = 1'b0;
        case (st_q)
            SYNC: st_d = (fill_q == 2'd3 && !s2_q) ? WAIT_RISE : SYNC;
            WAIT_RISE: if (rise) begin
                st_d   = HIGH;
                wcnt_d = '0;
                pcnt_d = '0;
            end
            HIGH: begin
                wcnt_d = w_inc;
                if (fall) begin
                    wlat_d = w_inc;
                    st_d   = LOW;
                end
            end
            default: if (rise) begin
                hand   = 1'b1;
                st_d   = HIGH;
                wcnt_d = '0;
                pcnt_d = '0;
            end
        endcase
        if (pcnt_d == P_SAT) begin
            tmo    = 1'b1;
            pcnt_d = '0;
            st_d   = SYNC;
        end
    end

    assign in_rng = (qw_q >= W_MIN) && (qw_q <= W_MAX);
    assign done   = !in_rng || (rem_q < W_BIN) || (qpos_q == 4'd9);

    always_comb begin
        cs_d   = cs_q;
        qw_d   = qw_q;
        qp_d   = qp_q;
        rem_d  = rem_q;
        qpos_d = qpos_q;
        wo_d   = wo_q;
        po_d   = po_q;
        pos_d  = pos_q;
        vld_d  = 1'b0;
        ok_d   = ok_q;
        err_d  = err_q;
        to_d   = to_q;
        if (cs_q == CALC && done) begin
            cs_d  = IDLE;
            wo_d  = qw_q;
            po_d  = qp_q;
            pos_d = in_rng ? qpos_q : 4'd10;
            vld_d = 1'b1;
            ok_d  = in_rng;
            err_d = !in_rng;
            to_d  = to_q & !in_rng;
        end else if (cs_q == CALC) begin
            rem_d  = rem_q - W_BIN;
            qpos_d = qpos_q + 4'd1;
        end
        // A new handoff replaces whatever is still being computed.
        if (hand) begin
            cs_d   = CALC;
            qw_d   = wlat_q;
            qp_d   = p_inc;
            rem_d  = wlat_q - W_MIN + W_HALF;
            qpos_d = '0;
        end
        if (tmo) begin
            to_d  = 1'b1;
            pos_d = 4'd10;
            ok_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            fill_q <= '0;
            st_q   <= SYNC;
            wcnt_q <= '0;
            wlat_q <= '0;
            pcnt_q <= '0;
            cs_q   <= IDLE;
            qw_q   <= '0;
            qp_q   <= '0;
            rem_q  <= '0;
            qpos_q <= '0;
            wo_q   <= '0;
            po_q   <= '0;
            pos_q  <= 4'd10;
            vld_q  <= 1'b0;
            ok_q   <= 1'b0;
            err_q  <= 1'b0;
            to_q   <= 1'b0;
        end else begin
            s1_q   <= bus.pwm_in;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            fill_q <= (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
            st_q   <= st_d;
            wcnt_q <= wcnt_d;
            wlat_q <= wlat_d;
            pcnt_q <= pcnt_d;
            cs_q   <= cs_d;
            qw_q   <= qw_d;
            qp_q   <= qp_d;
            rem_q  <= rem_d;
            qpos_q <= qpos_d;
            wo_q   <= wo_d;
            po_q   <= po_d;
            pos_q  <= pos_d;
            vld_q  <= vld_d;
            ok_q   <= ok_d;
            err_q  <= err_d;
            to_q   <= to_d;
        end
    end

    assign bus.width_o    = wo_q;
    assign bus.period_o   = po_q;
    assign bus.position_o = pos_q;
    assign bus.valid_o    = vld_q;
    assign bus.signal_ok  = ok_q;
    assign bus.err_range  = err_q;
    assign bus.timeout_o  = to_q;
endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: pulse trains (directed and random) checked every cycle against a
// measurement-level model of the decoder, with scaled-down timing parameters.
module tb_pwm_decoder;
    localparam int MIN = 50;
    localparam int MAX = 100;
    localparam int TO  = 1250;
    localparam int BIN = 5;
    localparam int LAT = 16;

    typedef struct {int w; int p; int t;} meas_t;

    logic clk_50MHz = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b1;
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int n_valid = 0;
    meas_t q[$];
    meas_t e;
    bit have_start = 1'b0;
    bit fell = 1'b0;
    int t_start = 0;
    int t_fall = 0;
    int t_ref = 0;
    int cur_w = 0, cur_p = 0, cur_pos = 10, cur_ok = 0, cur_err = 0, cur_to = 0;
    int el;

    pwm_decoder_if bus();

    pwm_decoder #(.MIN_PULSE(MIN), .MAX_PULSE(MAX), .TIMEOUT(TO), .BIN(BIN)) dut (
        .clk_50MHz(clk_50MHz),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    always @(posedge clk_50MHz) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    function automatic void chk(string name, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int quant(int w);
        int s;
        if (w < MIN || w > MAX) return 10;
        s = (w - MIN + BIN / 2) / BIN;
        return (s > 9) ? 9 : s;
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk_50MHz);
        #1;
    endtask

    task automatic drive_rise();
        if (have_start && fell && (cyc - t_start) < TO)
            q.push_back('{w: t_fall - t_start, p: cyc - t_start, t: cyc});
        have_start = 1'b1;
        fell       = 1'b0;
        t_start    = cyc;
        t_ref      = cyc;
        bus.pwm_in = 1'b1;
    endtask

    task automatic drive_fall();
        fell       = have_start;
        t_fall     = cyc;
        bus.pwm_in = 1'b0;
    endtask

    task automatic pulse(int hi, int per);
        drive_rise();
        tick(hi);
        drive_fall();
        tick(per - hi);
    endtask

    task automatic do_reset(int n);
        rst        = 1'b1;
        have_start = 1'b0;
        fell       = 1'b0;
        tick(n);
        rst   = 1'b0;
        t_ref = cyc;
    endtask

    task automatic chk_out(string tag, int w, int p, int pos, int ok, int err, int to);
        chk({tag, "_width"}, bus.width_o, w);
        chk({tag, "_period"}, bus.period_o, p);
        chk({tag, "_position"}, bus.position_o, pos);
        chk({tag, "_signal_ok"}, bus.signal_ok, ok);
        chk({tag, "_err_range"}, bus.err_range, err);
        chk({tag, "_timeout"}, bus.timeout_o, to);
    endtask

    always @(negedge clk_50MHz) begin
        if (rst_q) begin
            q.delete();
            n_valid = 0;
            cur_w = 0; cur_p = 0; cur_pos = 10; cur_ok = 0; cur_err = 0; cur_to = 0;
            chk("reset_valid", bus.valid_o, 0);
            chk("reset_width", bus.width_o, 0);
            chk("reset_position", bus.position_o, 10);
        end else begin
            el = cyc - t_ref;
            if (q.size() != 0 && !bus.valid_o) begin
                chk("publish_deadline", int'((cyc - q[0].t) <= LAT), 1);
                if ((cyc - q[0].t) > LAT) void'(q.pop_front());
            end
            if (bus.valid_o) begin
                n_valid++;
                chk("valid_expected", int'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    cur_w   = e.w;
                    cur_p   = e.p;
                    cur_pos = quant(e.w);
                    cur_err = int'(cur_pos == 10);
                    cur_ok  = 1 - cur_err;
                    cur_to  = cur_err ? cur_to : 0;
                end
            end else if (el >= TO + 5) begin
                cur_to  = 1;
                cur_pos = 10;
                cur_ok  = 0;
            end
            chk("width_o", bus.width_o, cur_w);
            chk("period_o", bus.period_o, cur_p);
            chk("err_range", bus.err_range, cur_err);
            if (bus.valid_o || el < TO || el >= TO + 5) begin
                chk("position_o", bus.position_o, cur_pos);
                chk("signal_ok", bus.signal_ok, cur_ok);
                chk("timeout_o", bus.timeout_o, cur_to);
            end
        end
    end

    initial begin
        int k, hi, per;
        bus.pwm_in = 1'b0;
        chk("model_q75", quant(75), 5);
        chk("model_q50", quant(50), 0);
        chk("model_q100", quant(100), 9);
        chk("model_q45", quant(45), 10);
        chk("model_q53", quant(53), 1);
        chk("model_q101", quant(101), 10);
        do_reset(5);
        chk_out("rst", 0, 0, 10, 0, 0, 0);
        chk("rst_valid", bus.valid_o, 0);
        tick(10);
        pulse(75, 1000);
        pulse(75, 1000);
        pulse(50, 1000);
        chk_out("nominal", 75, 1000, 5, 1, 0, 0);
        pulse(100, 1000);
        chk_out("min_edge", 50, 1000, 0, 1, 0, 0);
        pulse(45, 1000);
        chk_out("max_edge", 100, 1000, 9, 1, 0, 0);
        pulse(75, 1000);
        chk_out("short", 45, 1000, 10, 0, 1, 0);
        tick(1300);
        chk_out("lost", 45, 1000, 10, 0, 1, 1);
        pulse(75, 1000);
        pulse(75, 1000);
        chk_out("recover", 75, 1000, 5, 1, 0, 0);
        drive_rise();
        tick(20);
        do_reset(3);
        tick(40);
        drive_fall();
        tick(900);
        pulse(75, 1000);
        chk("partial_ignored", n_valid, 0);
        pulse(60, 1000);
        chk("first_after_partial", n_valid, 1);
        chk_out("after_partial", 75, 1000, 5, 1, 0, 0);
        drive_rise();
        tick(40);
        do_reset(1);
        chk_out("mid_high_rst", 0, 0, 10, 0, 0, 0);
        tick(40);
        drive_fall();
        tick(920);
        pulse(70, 1000);
        chk("interrupted_dropped", n_valid, 0);
        pulse(70, 1000);
        chk("resume_valid", n_valid, 1);
        chk("resume_width", bus.width_o, 70);
        for (int i = 0; i < 30; i++) begin
            k   = int'($urandom_range(0, 9));
            hi  = int'($urandom_range(40, 110));
            per = hi + int'($urandom_range(40, 1000));
            if (k == 0) per = hi + int'($urandom_range(1300, 1400));
            if (k == 1) begin
                hi  = int'($urandom_range(1300, 1400));
                per = hi + 200;
            end
            pulse(hi, per);
        end
        pulse(75, 1000);
        drive_rise();
        tick(40);
        chk("final_queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
